// File: rtl/alu_pkg.sv
// Shared types for the ALU request issuer: INP_VALID codes, multiply command ids,
// issuer FSM states and the queued request record.
package alu_pkg;

  localparam int DW = 8;   // operand width
  localparam int CW = 4;   // command width
  localparam int GW = 5;   // gap field width

  typedef enum logic [1:0] {
    IV_NONE = 2'b00,
    IV_A    = 2'b01,
    IV_B    = 2'b10,
    IV_AB   = 2'b11
  } inp_valid_e;

  localparam logic [CW-1:0] CMD_INC_MUL = 4'd9;
  localparam logic [CW-1:0] CMD_SHL_MUL = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_AB,
    S_ISSUE_A,
    S_GAP,
    S_ISSUE_B,
    S_WAIT
  } issuer_state_e;

  typedef struct packed {
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic [CW-1:0] cmd;
    logic          mode;
    logic          cin;
    logic          split;
    logic [GW-1:0] gap;
  } alu_req_t;

  // Arithmetic-mode multiply commands go through the ALU's extra pipeline stage.
  function automatic logic is_mul(input logic mode, input logic [CW-1:0] cmd);
    return mode && ((cmd == CMD_INC_MUL) || (cmd == CMD_SHL_MUL));
  endfunction

endpackage

// File: rtl/alu_req_issuer_if.sv
// Request handshake, ALU input bus and response strobe of the ALU request issuer.
// The slave modport is the issuer; the master modport is the requesting side.
interface alu_req_issuer_if;
  import alu_pkg::*;

  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] req_opa;
  logic [DW-1:0] req_opb;
  logic [CW-1:0] req_cmd;
  logic          req_mode;
  logic          req_cin;
  logic          req_split;
  logic [GW-1:0] req_gap;

  logic [1:0]    alu_inp_valid;
  logic [DW-1:0] alu_opa;
  logic [DW-1:0] alu_opb;
  logic [CW-1:0] alu_cmd;
  logic          alu_mode;
  logic          alu_cin;
  logic          alu_ce;

  logic          rsp_strobe;
  logic          rsp_tmo;
  logic          busy;

  modport slave (
    input  req_valid, req_opa, req_opb, req_cmd, req_mode, req_cin, req_split, req_gap,
    output req_ready, alu_inp_valid, alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, alu_ce,
           rsp_strobe, rsp_tmo, busy
  );

  modport master (
    output req_valid, req_opa, req_opb, req_cmd, req_mode, req_cin, req_split, req_gap,
    input  req_ready, alu_inp_valid, alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, alu_ce,
           rsp_strobe, rsp_tmo, busy
  );

endinterface

// File: rtl/alu_req_fifo.sv
// Synchronous FIFO of alu_req_t records, DEPTH entries (power of 2, >= 2),
// with first-word-fall-through read data and full/empty/count status.
module alu_req_fifo
  import alu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic     CLK,
  input  logic     RST,
  input  logic     push,
  input  logic     pop,
  input  alu_req_t wdata,
  output alu_req_t rdata,
  output logic     full,
  output logic     empty,
  output logic [AW:0] count
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  alu_req_t mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = do_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + CNT_ONE;
    if (do_pop && !do_push) count_d = count_q - CNT_ONE;
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count and pointers alone define which entries are valid.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/alu_req_issuer.sv
// ALU request issuer: queues requests and drives the ALU input bus whole or split,
// then strobes when the result is valid. Define ALU_REQ_STATS_EN for issue/timeout counters.
module alu_req_issuer
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16,
  parameter int LAT_STD = 1,
  parameter int LAT_MUL = 2
) (
  input  logic        CLK,
  input  logic        RST,
`ifdef ALU_REQ_STATS_EN
  output logic [15:0] stat_issued,
  output logic [15:0] stat_tmo,
`endif
  alu_req_issuer_if.slave bus
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [3:0]  LAT_STD_M1 = 4'(LAT_STD - 1);
  localparam logic [3:0]  LAT_MUL_M1 = 4'(LAT_MUL - 1);
  localparam logic [5:0]  TMO_C      = 6'(TIMEOUT);

  alu_req_t      fifo_head, fifo_wdata;
  logic          fifo_full, fifo_empty, pop;
  logic [AW:0]   fifo_count;

  issuer_state_e state_q, state_d;
  inp_valid_e    iv_q, iv_d;
  logic [DW-1:0] opa_q, opa_d, opb_q, opb_d, opb_pend_q, opb_pend_d;
  logic [CW-1:0] cmd_q, cmd_d;
  logic          mode_q, mode_d, cin_q, cin_d, ce_q, ce_d;
  logic [GW-1:0] gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic [3:0]    lat_q, lat_d, lat_first;
  logic          tmo_flag_q, tmo_flag_d, strobe_q, strobe_d, rsp_tmo_q, rsp_tmo_d;
  logic          go_b, can_dispatch;

  assign fifo_wdata = '{opa: bus.req_opa, opb: bus.req_opb, cmd: bus.req_cmd, mode: bus.req_mode,
                        cin: bus.req_cin, split: bus.req_split, gap: bus.req_gap};

  alu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (bus.req_valid),
    .pop   (pop),
    .wdata (fifo_wdata),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    // NOTE: every _d takes a default before any branch, so no path can infer a latch.
    state_d    = state_q;
    iv_d       = IV_NONE;
    opa_d      = opa_q;
    opb_d      = opb_q;
    opb_pend_d = opb_pend_q;
    cmd_d      = cmd_q;
    mode_d     = mode_q;
    cin_d      = cin_q;
    ce_d       = 1'b1;
    gap_d      = gap_q;
    gap_cnt_d  = gap_cnt_q;
    lat_d      = lat_q;
    tmo_flag_d = tmo_flag_q;
    strobe_d   = 1'b0;
    rsp_tmo_d  = 1'b0;
    pop        = 1'b0;
    go_b       = 1'b0;
    lat_first  = is_mul(mode_q, cmd_q) ? LAT_MUL_M1 : LAT_STD_M1;
    // The strobe cycle doubles as the dispatch slot so requests issue back-to-back.
    can_dispatch = (state_q == S_IDLE) || ((state_q == S_WAIT) && strobe_q);

    unique case (state_q)
      S_IDLE: ;
      S_ISSUE_AB, S_ISSUE_B: begin
        state_d   = S_WAIT;
        lat_d     = lat_first;
        strobe_d  = (lat_first == 4'd0);
        rsp_tmo_d = strobe_d && tmo_flag_q;
      end
      S_ISSUE_A: begin
        if (gap_q == '0) go_b = 1'b1;
        else begin
          state_d   = S_GAP;
          gap_cnt_d = 5'd1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == gap_q) go_b = 1'b1;
        else gap_cnt_d = (gap_cnt_q == '1) ? gap_cnt_q : gap_cnt_q + 5'd1;
      end
      S_WAIT: begin
        if (strobe_q) state_d = S_IDLE;
        else begin
          lat_d     = lat_q - 4'd1;
          strobe_d  = (lat_q == 4'd1);
          rsp_tmo_d = strobe_d && tmo_flag_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (go_b) begin
      state_d    = S_ISSUE_B;
      iv_d       = IV_B;
      opb_d      = opb_pend_q;
      tmo_flag_d = ({1'b0, gap_q} >= TMO_C);
    end

    if (can_dispatch && !fifo_empty) begin
      pop        = 1'b1;
      cmd_d      = fifo_head.cmd;
      mode_d     = fifo_head.mode;
      cin_d      = fifo_head.cin;
      gap_d      = fifo_head.gap;
      opb_pend_d = fifo_head.opb;
      opa_d      = fifo_head.opa;
      tmo_flag_d = 1'b0;
      if (fifo_head.split) begin
        state_d = S_ISSUE_A;
        iv_d    = IV_A;
      end else begin
        state_d = S_ISSUE_AB;
        iv_d    = IV_AB;
        opb_d   = fifo_head.opb;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      iv_q       <= IV_NONE;
      opa_q      <= '0;
      opb_q      <= '0;
      opb_pend_q <= '0;
      cmd_q      <= '0;
      mode_q     <= 1'b0;
      cin_q      <= 1'b0;
      ce_q       <= 1'b1;
      gap_q      <= '0;
      gap_cnt_q  <= '0;
      lat_q      <= '0;
      tmo_flag_q <= 1'b0;
      strobe_q   <= 1'b0;
      rsp_tmo_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      iv_q       <= iv_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      opb_pend_q <= opb_pend_d;
      cmd_q      <= cmd_d;
      mode_q     <= mode_d;
      cin_q      <= cin_d;
      ce_q       <= ce_d;
      gap_q      <= gap_d;
      gap_cnt_q  <= gap_cnt_d;
      lat_q      <= lat_d;
      tmo_flag_q <= tmo_flag_d;
      strobe_q   <= strobe_d;
      rsp_tmo_q  <= rsp_tmo_d;
    end
  end

  assign bus.req_ready     = !fifo_full;
  assign bus.busy          = (state_q != S_IDLE) || (fifo_count != '0);
  assign bus.alu_inp_valid = iv_q;
  assign bus.alu_opa       = opa_q;
  assign bus.alu_opb       = opb_q;
  assign bus.alu_cmd       = cmd_q;
  assign bus.alu_mode      = mode_q;
  assign bus.alu_cin       = cin_q;
  assign bus.alu_ce        = ce_q;
  assign bus.rsp_strobe    = strobe_q;
  assign bus.rsp_tmo       = rsp_tmo_q;

`ifdef ALU_REQ_STATS_EN
  logic [15:0] stat_issued_q, stat_issued_d, stat_tmo_q, stat_tmo_d;

  always_comb begin
    stat_issued_d = stat_issued_q;
    stat_tmo_d    = stat_tmo_q;
    if (strobe_q && (stat_issued_q != 16'hFFFF)) stat_issued_d = stat_issued_q + 16'd1;
    if (strobe_q && rsp_tmo_q && (stat_tmo_q != 16'hFFFF)) stat_tmo_d = stat_tmo_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_issued_q <= '0;
      stat_tmo_q    <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_tmo_q    <= stat_tmo_d;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_tmo    = stat_tmo_q;
`endif

endmodule

// File: tb/tb_alu_req_issuer.sv
// Self-checking bench for alu_req_issuer: a per-cycle timeline model built from the
// issue rules predicts every bus cycle; directed steps plus randomized requests drive it.
module tb_alu_req_issuer;
  import alu_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int LAT_STD = 1;
  localparam int LAT_MUL = 2;
  localparam int MAXC    = 8192;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  alu_req_issuer_if bus();

`ifdef ALU_REQ_STATS_EN
  logic [15:0] stat_issued, stat_tmo;
`endif

  alu_req_issuer #(
    .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .LAT_STD(LAT_STD), .LAT_MUL(LAT_MUL)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
`ifdef ALU_REQ_STATS_EN
    .stat_issued (stat_issued),
    .stat_tmo    (stat_tmo),
`endif
    .bus         (bus)
  );

  // Expected timeline, indexed by cycle number.
  bit [1:0] exp_iv     [MAXC];
  bit       exp_strobe [MAXC];
  bit       exp_tmo    [MAXC];
  bit       exp_active [MAXC];
  bit       exp_first  [MAXC];
  bit [7:0] exp_opa    [MAXC];
  bit [7:0] exp_opb    [MAXC];
  bit [3:0] exp_cmd    [MAXC];
  bit       exp_mode   [MAXC];
  bit       exp_cin    [MAXC];
  int       occ_delta  [MAXC];

  int       cyc, occ_cur, last_s, last_f, st_iss, st_tmo;
  int       n_cmp, n_err;
  bit       accepted;
  bit [7:0] cur_opa, cur_opb;
  bit [3:0] cur_cmd;
  bit       cur_mode, cur_cin;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic alu_req_t mk(input bit [7:0] a, input bit [7:0] b, input bit [3:0] cmd,
                                  input bit mode, input bit cin, input bit split, input bit [4:0] gap);
    alu_req_t r;
    r.opa = a; r.opb = b; r.cmd = cmd; r.mode = mode; r.cin = cin; r.split = split; r.gap = gap;
    return r;
  endfunction

  function automatic alu_req_t rand_req();
    bit [4:0] g;
    g = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(14, 31)) : 5'($urandom_range(0, 4));
    return mk(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom),
              1'($urandom), 1'($urandom), g);
  endfunction

  // A request pushed in cycle c first issues at c+2, or right after the previous strobe.
  task automatic model_push(input int c, input alu_req_t r);
    int f, b, s, lat;
    f = (c + 2 > last_s + 1) ? c + 2 : last_s + 1;
    occ_delta[c + 1]++;
    occ_delta[f]--;
    exp_first[f] = 1'b1;
    exp_cmd[f]   = r.cmd;
    exp_mode[f]  = r.mode;
    exp_cin[f]   = r.cin;
    exp_opa[f]   = r.opa;
    if (r.split) begin
      exp_iv[f]  = 2'b01;
      b          = f + int'(r.gap) + 1;
      exp_iv[b]  = 2'b10;
      exp_opb[b] = r.opb;
    end else begin
      exp_iv[f]  = 2'b11;
      exp_opb[f] = r.opb;
      b          = f;
    end
    lat = (r.mode && (r.cmd == 4'd9 || r.cmd == 4'd10)) ? LAT_MUL : LAT_STD;
    s = b + lat;
    exp_strobe[s] = 1'b1;
    exp_tmo[s]    = r.split && (int'(r.gap) >= TIMEOUT);
    for (int i = f; i <= s; i++) exp_active[i] = 1'b1;
    last_s = s;
    last_f = f;
  endtask

  // Reset sampled at the end of cycle c wipes everything expected from c+1 on.
  task automatic model_clear(input int c);
    for (int i = c + 1; i < MAXC; i++) begin
      exp_iv[i] = '0; exp_strobe[i] = 0; exp_tmo[i] = 0; exp_active[i] = 0; exp_first[i] = 0;
      occ_delta[i] = 0;
    end
    occ_cur = 0; last_s = -10; last_f = -10;
    cur_opa = '0; cur_opb = '0; cur_cmd = '0; cur_mode = 0; cur_cin = 0;
    st_iss = 0; st_tmo = 0;
  endtask

  task automatic step(input bit rst, input bit valid, input alu_req_t r);
    RST           = rst;
    bus.req_valid = valid;
    bus.req_opa   = r.opa;
    bus.req_opb   = r.opb;
    bus.req_cmd   = r.cmd;
    bus.req_mode  = r.mode;
    bus.req_cin   = r.cin;
    bus.req_split = r.split;
    bus.req_gap   = r.gap;
    occ_cur += occ_delta[cyc];
    if (exp_iv[cyc][0]) cur_opa = exp_opa[cyc];
    if (exp_iv[cyc][1]) cur_opb = exp_opb[cyc];
    if (exp_first[cyc]) begin
      cur_cmd = exp_cmd[cyc]; cur_mode = exp_mode[cyc]; cur_cin = exp_cin[cyc];
    end
    @(negedge CLK);
    check("inp_valid",  bus.alu_inp_valid, exp_iv[cyc]);
    check("rsp_strobe", bus.rsp_strobe,    exp_strobe[cyc]);
    check("rsp_tmo",    bus.rsp_tmo,       exp_tmo[cyc]);
    check("req_ready",  bus.req_ready,     occ_cur < DEPTH);
    check("busy",       bus.busy,          exp_active[cyc] || occ_cur > 0);
    check("alu_ce",     bus.alu_ce,        1);
    check("alu_opa",    bus.alu_opa,       cur_opa);
    check("alu_opb",    bus.alu_opb,       cur_opb);
    check("alu_cmd",    bus.alu_cmd,       cur_cmd);
    check("alu_mode",   bus.alu_mode,      cur_mode);
    check("alu_cin",    bus.alu_cin,       cur_cin);
`ifdef ALU_REQ_STATS_EN
    check("stat_issued", stat_issued, st_iss);
    check("stat_tmo",    stat_tmo,    st_tmo);
`endif
    if (exp_strobe[cyc]) begin
      if (st_iss < 65535) st_iss++;
      if (exp_tmo[cyc] && st_tmo < 65535) st_tmo++;
    end
    accepted = valid && !rst && (occ_cur < DEPTH);
    if (accepted) model_push(cyc, r);
    if (rst) model_clear(cyc);
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  task automatic send(input alu_req_t r);
    int tries;
    tries    = 0;
    accepted = 1'b0;
    while (!accepted && tries < 200) begin
      step(1'b0, 1'b1, r);
      tries++;
    end
    if (!accepted) begin
      n_cmp++;
      n_err++;
      $error("FAIL send_timeout cyc=%0d observed=not_accepted expected=accepted", cyc);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (cyc <= last_s + 1 && k < 600) begin
      step(1'b0, 1'b0, '0);
      k++;
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    bus.req_valid = 1'b0; bus.req_opa = '0; bus.req_opb = '0; bus.req_cmd = '0;
    bus.req_mode = 1'b0; bus.req_cin = 1'b0; bus.req_split = 1'b0; bus.req_gap = '0;
    model_clear(-1);
    @(posedge CLK);
    #1;

    // Reset state, then release.
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    idle(2);

    // Unsplit add: one 11 cycle, strobe one cycle later.
    send(mk(8'h0F, 8'h01, 4'd0, 1'b1, 1'b0, 1'b0, 5'd0));
    drain();

    // Split issues: gap 3, gap 0, TIMEOUT boundary 15/16, maximum gap 31.
    send(mk(8'h11, 8'h22, 4'd1, 1'b0, 1'b1, 1'b1, 5'd3));
    drain();
    send(mk(8'h33, 8'h44, 4'd2, 1'b1, 1'b0, 1'b1, 5'd0));
    drain();
    send(mk(8'h55, 8'h66, 4'd3, 1'b1, 1'b1, 1'b1, 5'd15));
    drain();
    send(mk(8'h77, 8'h88, 4'd0, 1'b1, 1'b0, 1'b1, 5'd16));
    drain();
    send(mk(8'h99, 8'hAA, 4'd4, 1'b0, 1'b0, 1'b1, 5'd31));
    drain();

    // Multiply latency: arithmetic cmd 9/10 take LAT_MUL, logic-mode cmd 9 does not.
    send(mk(8'h02, 8'h03, 4'd9,  1'b1, 1'b0, 1'b0, 5'd0));
    drain();
    send(mk(8'h04, 8'h05, 4'd10, 1'b1, 1'b0, 1'b1, 5'd2));
    drain();
    send(mk(8'h06, 8'h07, 4'd9,  1'b0, 1'b0, 1'b0, 5'd0));
    drain();

    // Back-to-back burst deep enough to fill the FIFO.
    for (int i = 0; i < 6; i++) send(mk(8'(i), 8'(i + 8'h40), 4'd0, 1'b1, 1'b0, 1'b1, 5'd5));
    for (int i = 0; i < 5; i++) send(mk(8'(i + 8'h80), 8'(i), 4'd9, 1'b1, 1'b1, 1'b0, 5'd0));
    drain();

    // Randomized traffic.
    for (int i = 0; i < 120; i++) begin
      idle($urandom_range(0, 2));
      send(rand_req());
    end
    drain();

    // Reset in the middle of a gap: the pending half and strobe never appear.
    send(mk(8'hC3, 8'h3C, 4'd5, 1'b1, 1'b0, 1'b1, 5'd10));
    while (cyc < last_f + 3) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    idle(20);

    // Three requests, one of them timing out.
    send(mk(8'h01, 8'h02, 4'd0, 1'b1, 1'b0, 1'b0, 5'd0));
    send(mk(8'h03, 8'h04, 4'd1, 1'b1, 1'b0, 1'b1, 5'd20));
    send(mk(8'h05, 8'h06, 4'd2, 1'b0, 1'b1, 1'b1, 5'd1));
    drain();
`ifdef ALU_REQ_STATS_EN
    check("stat_issued_final", stat_issued, 3);
    check("stat_tmo_final",    stat_tmo,    1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
